riscv_mc_controller: RTL and testbench

- Moore-style main controller for the multi-cycle RV32I core. Sits directly upstream of the ALU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath mux selects, write enables and the 3-bit ALU control word.
- Contains the ALU decoder. The ALU consumes `alu_control`; its `zero` flag returns here to resolve beq.

---
 rtl/riscv_mc_controller.sv | 183 ++++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I main controller: Moore sequencer, immediate-format and ALU decoders.
// Drives every datapath select and enable for fetch, decode, execute, memory and writeback.
`timescale 1ns/1ps

module riscv_mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        w_next_state = S_FETCH;
        w_alu_op     = 2'b00;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        adr_src      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;

        case (r_state)
            S_FETCH: begin
                ir_write     = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                w_pc_update  = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes old PC + imm as the branch/jump target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECUTER;
                    OP_ITYPE:          w_next_state = S_EXECUTEI;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_BEQ:            w_next_state = S_BEQ;
                    default: begin
                        illegal_op   = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                w_next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src      = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src   = 2'b01;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src      = 1'b1;
                mem_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a    = 2'b10;
                w_alu_op     = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                w_alu_op     = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a    = 2'b10;
                w_alu_op     = 2'b01;
                w_branch     = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // Link value old PC + 4 goes through ALUWB while the target loads into PC.
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE: imm_src = 2'b01;
            OP_BEQ:   imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    always_comb begin
        case (w_alu_op)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    // Only R-type (op[5]=1) may subtract; addi with instr[30] set stays add.
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    assign pc_write = w_pc_update | (w_branch & zero);

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench for riscv_mc_controller: per-cycle expectations from an instruction-level model.
`timescale 1ns/1ps

module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       instr_done, illegal_op;

    riscv_mc_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .alu_control(alu_control),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    typedef enum {K_LW, K_SW, K_R, K_I, K_JAL, K_BEQ, K_ILL} kind_t;

    outs_t sb_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    n_step = 0;

    function automatic kind_t kind_of(input logic [6:0] o);
        case (o)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b1101111: return K_JAL;
            7'b1100011: return K_BEQ;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic int cycles_of(input kind_t kd);
        case (kd)
            K_LW:    return 5;
            K_BEQ:   return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] alu_fn(input kind_t kd, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (kd == K_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = fetch) of one instruction.
    function automatic outs_t model(input logic [6:0] o, input logic [2:0] f3,
                                    input logic f7, input logic z, input int k);
        outs_t e;
        kind_t kd;
        logic  last;
        e    = '0;
        kd   = kind_of(o);
        last = (k == cycles_of(kd) - 1);
        e.imm_src = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
                    (o == 7'b1101111) ? 2'b11 : 2'b00;
        if (k == 0) begin
            e.pc_write   = 1'b1;
            e.ir_write   = 1'b1;
            e.alu_src_b  = 2'b10;
            e.result_src = 2'b10;
            return e;
        end
        if (k == 1) begin
            e.alu_src_a  = 2'b01;
            e.alu_src_b  = 2'b01;
            e.illegal_op = (kd == K_ILL);
            return e;
        end
        e.instr_done = last;
        e.reg_write  = last && (kd == K_LW || kd == K_R || kd == K_I || kd == K_JAL);
        e.mem_write  = last && (kd == K_SW);
        e.adr_src    = (kd == K_LW || kd == K_SW) && k == 3;
        if (kd == K_LW && k == 4) e.result_src = 2'b01;
        if (k == 2) begin
            case (kd)
                K_LW, K_SW: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
                K_R: begin
                    e.alu_src_a   = 2'b10;
                    e.alu_control = alu_fn(kd, f3, f7);
                end
                K_I: begin
                    e.alu_src_a   = 2'b10;
                    e.alu_src_b   = 2'b01;
                    e.alu_control = alu_fn(kd, f3, f7);
                end
                K_BEQ: begin
                    e.alu_src_a   = 2'b10;
                    e.alu_control = 3'b001;
                    e.pc_write    = z;
                end
                K_JAL: begin
                    e.alu_src_a = 2'b01;
                    e.alu_src_b = 2'b10;
                    e.pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic outs_t sample();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, instr_done, illegal_op};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            outs_t e;
            e = sb_q.pop_front();
            n_step++;
            check($sformatf("step%0d op=%b", n_step, op), 32'(sample()), 32'(e));
        end
    end

    // Call at posedge+1 with the DUT in fetch; returns at posedge+1 of the next fetch.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        int n;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        n = cycles_of(kind_of(o));
        for (int k = 0; k < n; k++) sb_q.push_back(model(o, f3, f7, z, k));
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) sb_q.push_back(model(op, funct3, funct7b5, zero, 0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);   // lw
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b1);   // sw
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);   // sub
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);   // addi, instr[30] set
        run_instr(7'b0010011, 3'b010, 1'b0, 1'b0);   // slti
        run_instr(7'b0010011, 3'b110, 1'b0, 1'b0);   // ori
        run_instr(7'b0010011, 3'b111, 1'b0, 1'b0);   // andi
        run_instr(7'b0010011, 3'b001, 1'b0, 1'b0);   // unsupported funct3 -> add
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);   // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);   // beq not taken
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0);   // jal
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0);   // lui: illegal here

        // Abort a load in MEMREAD with an asynchronous reset.
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        for (int k = 0; k < 4; k++) sb_q.push_back(model(op, funct3, funct7b5, zero, k));
        repeat (3) @(posedge clk);
        #6;
        rst_n = 1'b0;
        #1;
        check("async_rst ir_write", 32'(ir_write), 32'd1);
        check("async_rst adr_src", 32'(adr_src), 32'd0);
        check("async_rst reg_write", 32'(reg_write), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [6:0] o;
            case ($urandom_range(0, 7))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1101111;
                5: o = 7'b1100011;
                default: o = 7'($urandom);
            endcase
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk); #1;
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
